// File: rtl/ppc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppc_pkg
// Description : Shared definitions for the per-port pipeline controller:
//               packet FSM state encoding and the FIFO flit entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package ppc_pkg;

    // Packet FSM state encoding (2-bit, legacy-compatible values)
    typedef logic [1:0] ppc_state_t;

    localparam logic [1:0] PPC_IDLE  = 2'd0;
    localparam logic [1:0] PPC_ROUTE = 2'd1;
    localparam logic [1:0] PPC_FWD   = 2'd2;

    // Default flit width used by the flit entry type below
    localparam int PPC_DW_DEF = 32;

    // One FIFO entry: end-of-packet marker above the flit payload.
    // The channel FIFO stores entries with exactly this {eof, data} layout.
    typedef struct packed {
        logic                  eof;
        logic [PPC_DW_DEF-1:0] data;
    } ppc_flit_t;

endpackage
`default_nettype wire

// File: rtl/ppc_sync_ch.sv
`default_nettype none
// ============================================================================
// Module      : ppc_sync_ch
// Description : One sub-channel of the pipeline controller: a DEPTH-entry flit
//               FIFO plus a packet FSM that requests a route for each packet
//               head, then forwards flits until the EOF flit leaves.
// Revision    : 1.0 - initial release
// ============================================================================
module ppc_sync_ch #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    // link receiver side
    input  logic          i_in_vld,
    input  logic [DW-1:0] i_in_data,
    input  logic          i_in_eof,
    output logic          o_in_rdy,
    // routing decoder side
    output logic          o_dec_req,
    output logic [DW-1:0] o_dec_hdr,
    input  logic          i_dec_ack,
    // crossbar side
    output logic          o_out_vld,
    output logic [DW-1:0] o_out_data,
    output logic          o_out_eof,
    input  logic          i_out_rdy,
    // status
    output logic          o_eof_done,
    output logic          o_busy
);
    import ppc_pkg::*;

    localparam int             c_PTR_W = $clog2(DEPTH);
    localparam int             c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    // FIFO storage: each entry is {eof, data}
    logic [DW:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;
    ppc_state_t           r_state;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head_eof;
    logic [DW-1:0]        w_head_data;

    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);
    assign w_head_data = r_mem[r_rptr][DW-1:0];
    assign w_head_eof  = r_mem[r_rptr][DW];

    // Ready comes from registered occupancy only, so a full FIFO refuses a
    // push even when a pop happens in the same cycle.
    assign o_in_rdy  = ~w_full & ~rst;
    assign w_push    = i_in_vld & o_in_rdy;

    // All outward signalling is held low while reset is asserted.
    assign o_out_vld  = (r_state == PPC_FWD) & ~w_empty & ~rst;
    assign w_pop      = o_out_vld & i_out_rdy;
    assign o_out_data = o_out_vld ? w_head_data : '0;
    assign o_out_eof  = o_out_vld & w_head_eof;

    // The head stays in the FIFO while it is offered to the decoder.
    assign o_dec_req  = (r_state == PPC_ROUTE) & ~rst;
    assign o_dec_hdr  = o_dec_req ? w_head_data : '0;

    assign o_eof_done = w_pop & w_head_eof;
    assign o_busy     = (r_state != PPC_IDLE) & ~rst;

    // Write accepted flits into storage (payload needs no reset)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_in_eof, i_in_data};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Packet FSM: route the head, forward until EOF leaves, then rearm
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PPC_IDLE;
        end else begin
            case (r_state)
                PPC_IDLE:  if (!w_empty)   r_state <= PPC_ROUTE;
                PPC_ROUTE: if (i_dec_ack)  r_state <= PPC_FWD;
                PPC_FWD:   if (o_eof_done) r_state <= PPC_IDLE;
                default:                   r_state <= PPC_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppc_sync.sv
`default_nettype none
// ============================================================================
// Module      : ppc_sync
// Description : Synchronous per-port pipeline controller for the SDM router
//               input buffer. NCH fully independent sub-channels, each with
//               its own flit FIFO and packet FSM; this level only slices the
//               flat buses onto the channel instances.
// Revision    : 1.0 - initial release
// ============================================================================
module ppc_sync #(
    parameter int NCH   = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    in_vld,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH-1:0]    in_eof,
    output logic [NCH-1:0]    in_rdy,
    output logic [NCH-1:0]    dec_req,
    output logic [NCH*DW-1:0] dec_hdr,
    input  logic [NCH-1:0]    dec_ack,
    output logic [NCH-1:0]    out_vld,
    output logic [NCH*DW-1:0] out_data,
    output logic [NCH-1:0]    out_eof,
    input  logic [NCH-1:0]    out_rdy,
    output logic [NCH-1:0]    eof_done,
    output logic [NCH-1:0]    busy
);
    import ppc_pkg::*;

    // One self-contained controller per sub-channel; no shared state
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        ppc_sync_ch #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_in_vld   (in_vld[g]),
            .i_in_data  (in_data[g*DW +: DW]),
            .i_in_eof   (in_eof[g]),
            .o_in_rdy   (in_rdy[g]),
            .o_dec_req  (dec_req[g]),
            .o_dec_hdr  (dec_hdr[g*DW +: DW]),
            .i_dec_ack  (dec_ack[g]),
            .o_out_vld  (out_vld[g]),
            .o_out_data (out_data[g*DW +: DW]),
            .o_out_eof  (out_eof[g]),
            .i_out_rdy  (out_rdy[g]),
            .o_eof_done (eof_done[g]),
            .o_busy     (busy[g])
        );
    end

endmodule
`default_nettype wire

// File: doc/ppc_sync.md
Name: ppc_sync

Overview:
Synchronous, parametrised successor to the per-port pipeline controller of the SDM router input buffer. It serves NCH independent sub-channels. Each sub-channel has:
- a DEPTH-entry flit FIFO,
- a packet FSM that issues one routing request per packet head,
- a completion pulse when the EOF flit leaves.

It sits between the link receiver and the crossbar, replacing the C-element based EOF/decoder acknowledge logic with clocked valid/ready handshakes.

Parameters:
NCH, 4, number of sub-channels (>=1)
DW, 32, flit data width per sub-channel
DEPTH, 4, FIFO entries per sub-channel (power of 2, >=2)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous active-high reset
in_vld  input  NCH  flit valid per sub-channel
in_data  input  NCH*DW  flit data, sub-channel i at [i*DW +: DW]
in_eof  input  NCH  flit is last of packet
in_rdy  output  NCH  sub-channel can accept a flit
dec_req  output  NCH  routing request for current packet head
dec_hdr  output  NCH*DW  head flit data presented to the routing decoder
dec_ack  input  NCH  decoder accepted request (route latched downstream)
out_vld  output  NCH  flit valid toward crossbar
out_data  output  NCH*DW  flit data out
out_eof  output  NCH  out flit is last of packet
out_rdy  input  NCH  crossbar accepts flit
eof_done  output  NCH  one-cycle pulse: EOF flit transferred out
busy  output  NCH  sub-channel holds an unfinished packet (state != IDLE)

Behaviour:
- Reset and interface:
  - Single clock; reset synchronous active-high.
  - While rst=1 and on the first cycle after it: FIFOs empty, all FSMs IDLE, every output 0 (in_rdy forced 0 during rst).
  - in_rdy = ~full & ~rst.
- Per sub-channel, fully independent; no cross-channel arbitration.
- FIFO:
  - Push when in_vld & in_rdy; each entry stores {eof, data}.
  - Pop when out_vld & out_rdy. The occupancy counter is DEPTH-aware ($clog2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
  - in_rdy derives from registered occupancy: a full FIFO refuses a push even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: occupancy unchanged.
- FSM states, IDLE / ROUTE / FWD (2-bit encoding):
  - IDLE: if FIFO non-empty, go to ROUTE next cycle. The FIFO head is by definition a packet head.
  - ROUTE:
    - dec_req=1 and dec_hdr=FIFO head data; head is not popped and out_vld=0.
    - On dec_ack=1, go to FWD next cycle; otherwise hold, with dec_req stable until ack.
  - FWD:
    - out_vld = ~empty; out_data/out_eof = FIFO head.
    - When a flit with eof=1 pops: eof_done=1 that same cycle, then IDLE next cycle.
    - Further packets queued behind it wait for the next IDLE->ROUTE pass.
- dec_ack outside ROUTE is ignored; no state change.
- dec_hdr is 0 when not in ROUTE.
- Single-flit packet (head carries eof): ROUTE -> FWD -> pops -> eof_done -> IDLE.
- Latency, with immediate dec_ack and out_rdy:
  - Flit pushed in cycle t.
  - IDLE sees non-empty at t+1; dec_req at t+2.
  - FWD and out_vld at t+3.
  - Throughput 1 flit/cycle/sub-channel in FWD.
- Back-to-back packets: at least 2 bubble cycles (IDLE, ROUTE) between EOF out and next head out.
- busy = (state != IDLE).
- Reset mid-packet: discards all queued flits and returns to IDLE with no eof_done; upstream retransmission is not this block's concern.

Decomposition:
- Shared package ppc_pkg:
  - state typedef/localparams PPC_IDLE=2'd0, PPC_ROUTE=2'd1, PPC_FWD=2'd2;
  - flit entry struct {eof, data}.
- One natural sub-module, ppc_sync_ch: a single sub-channel holding the FIFO plus FSM.
- ppc_sync is a generate loop of NCH instances doing only bus slicing.

Test Plan:
- NCH=2, DEPTH=4, ch0 single flit data=32'hA5, eof=1, dec_ack held 1, out_rdy=1:
  - dec_req high exactly 1 cycle;
  - out_data=32'hA5 with out_eof=1 three cycles after push;
  - eof_done pulses once; busy returns 0.
- ch1 4-flit packet 1..4 (eof on 4), dec_ack delayed 3 cycles:
  - dec_hdr=1 stable for 4 cycles;
  - out sequence 1,2,3,4 on consecutive cycles;
  - eof_done coincides with flit 4.
- out_rdy=0, push 5 flits on ch0:
  - in_rdy drops after 4 accepted;
  - 5th held by upstream;
  - releasing out_rdy drains in order with no loss or duplication.
- dec_ack=1 while ch0 in IDLE, FIFO empty: no state change, no dec_req, busy stays 0.
- Two packets pushed back-to-back on ch0 and ch1 concurrently with random out_rdy:
  - each channel's output order matches its input order;
  - channels never interfere;
  - exactly 2 dec_req rising edges per channel.
- rst asserted mid-FWD after 2 of 4 flits out:
  - next cycle all outputs 0, no eof_done;
  - after deassert, a new packet completes normally.
